instr_fetch_seq: RTL and testbench
==================================

// Module: instr_fetch_seq
// PURPOSE
//   Program sequencer in front of the instruction decoder. Owns the PC, reads
//   instructions from a synchronous instruction memory and presents one at a time
//   to the decoder with a valid/next_instr handshake. Applies taken jumps, inserts
//   stall cycles for memory ops (1001/1010), and stops on the halt opcode.
// PARAMETERS
//   WIDTH_INSTR   16       instruction width; opcode = instr[WIDTH_INSTR-1 -: 4]
//   WIDTH_VECTOR  8        PC / instruction-address width (matches addr_instr)
//   MEM_LAT       2        stall cycles after an accepted 1001/1010 instr; 0 legal
//   HALT_OP       4'b1111  opcode that stops sequencing
// PORTS
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    pulse; honoured only in IDLE or HALT
//   start_addr  in   WV   PC loaded on honoured start
//   imem_rd     out  1    instruction memory read strobe
//   imem_addr   out  WV   read address (= pc)
//   imem_rdata  in   WI   read data, valid the cycle after imem_rd
//   instr       out  WI   registered instruction to decoder
//   valid       out  1    instr valid
//   next_instr  in   1    decoder accepts instr when valid & next_instr
//   jump        in   1    taken-jump flag from decoder, same cycle as accept
//   addr_instr  in   WV   jump target from decoder
//   pc          out  WV   address of instr currently held
//   busy        out  1    state not IDLE/HALT
//   halted      out  1    state == HALT
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, pc=0, instr=0, valid=0, imem_rd=0,
//     busy=0, halted=0; effective immediately, including mid-fetch or mid-stall.
//   States: IDLE, FETCH, WAIT, ISSUE, MEMW, HALT.
//   IDLE/HALT: start=1 -> pc<=start_addr, go FETCH; else stay. start elsewhere ignored.
//   FETCH (1 cyc): imem_rd=1, imem_addr=pc -> WAIT.
//   WAIT (1 cyc): instr<=imem_rdata at cycle end -> ISSUE.
//   ISSUE: valid=1, instr/pc held stable while next_instr=0 (unbounded).
//     On accept (next_instr=1), priority order:
//       opcode==HALT_OP          -> HALT (pc unchanged)
//       opcode==1100 & jump      -> pc<=addr_instr, FETCH
//       opcode 1001/1010, MEM_LAT>0 -> pc<=pc+1, cnt<=MEM_LAT-1, MEMW
//       otherwise                -> pc<=pc+1, FETCH
//     jump ignored unless opcode==1100 and accepted.
//   MEMW: valid=0; cnt==0 -> FETCH, else cnt<=cnt-1 (exactly MEM_LAT cycles).
//   valid=1 only in ISSUE; imem_rd=1 only in FETCH.
//   pc+1 is modulo 2**WV (0xFF -> 0x00 for WV=8); jump target taken verbatim.
//   Throughput: 3 cycles/instr (FETCH, WAIT, ISSUE) with next_instr=1.
//   instr retains last value outside ISSUE; no output depends combinationally on
//   next_instr except the next-state decision.
// TESTING
//   1 reset: rst_n=0 mid-WAIT -> same-cycle IDLE, valid=0, imem_rd=0, pc=0, busy=0.
//   2 sequential: start_addr=0x10, next_instr=1, nops -> imem_addr 0x10,0x11,0x12,
//     valid pulse every 3rd cycle, pc matches each instr.
//   3 backpressure: next_instr=0 for 4 cycles in ISSUE -> valid=1, instr/pc stable,
//     no imem_rd; release -> pc+1 fetched.
//   4 jump: at pc=0x05 opcode 1100, jump=1, addr_instr=0x40 -> next imem_addr=0x40;
//     repeat with jump=0 -> 0x06; opcode 0000 with jump=1 -> 0x06.
//   5 mem stall: accept opcode 1001, MEM_LAT=2 -> 2 cycles MEMW (valid=0,
//     imem_rd=0) then FETCH pc+1; MEM_LAT=0 build -> direct FETCH.
//   6 wrap/halt: start_addr=0xFF -> next fetch 0x00; accept HALT_OP -> halted=1,
//     busy=0, no further imem_rd; start, start_addr=0x20 -> FETCH 0x20.

Source files
------------

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq
// Purpose  : Program sequencer in front of the instruction decoder. Owns the
//            PC, reads a synchronous instruction memory, presents one
//            instruction at a time with a valid/next_instr handshake, applies
//            taken jumps, stalls after memory ops and stops on the halt opcode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_seq #(
   parameter int          WIDTH_INSTR  = 16,
   parameter int          WIDTH_VECTOR = 8,
   parameter int          MEM_LAT      = 2,
   parameter logic [3:0]  HALT_OP      = 4'b1111
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [WIDTH_VECTOR-1:0] start_addr,
   output logic                    imem_rd,
   output logic [WIDTH_VECTOR-1:0] imem_addr,
   input  logic [WIDTH_INSTR-1:0]  imem_rdata,
   output logic [WIDTH_INSTR-1:0]  instr,
   output logic                    valid,
   input  logic                    next_instr,
   input  logic                    jump,
   input  logic [WIDTH_VECTOR-1:0] addr_instr,
   output logic [WIDTH_VECTOR-1:0] pc,
   output logic                    busy,
   output logic                    halted
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_ISSUE = 3'd3,
      S_MEMW  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   // Stall counter only needs to hold MEM_LAT-1; keep at least one bit.
   localparam int               CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
   localparam bit               HAS_STALL = (MEM_LAT > 0);
   localparam logic [3:0]       OP_JUMP   = 4'b1100;
   localparam logic [3:0]       OP_LOAD   = 4'b1001;
   localparam logic [3:0]       OP_STORE  = 4'b1010;

   state_t                  state, state_nxt;
   logic [WIDTH_VECTOR-1:0] pc_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [3:0]              opcode;
   logic                    is_mem_op;

   assign opcode    = instr[WIDTH_INSTR-1 -: 4];
   assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

   // State register; reset takes effect immediately from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decision plus the PC / stall-counter updates that go with it.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_nxt    = start_addr;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (next_instr) begin
               if (opcode == HALT_OP) begin
                  state_nxt = S_HALT;
               end else if ((opcode == OP_JUMP) && jump) begin
                  pc_nxt    = addr_instr;
                  state_nxt = S_FETCH;
               end else if (is_mem_op && HAS_STALL) begin
                  pc_nxt    = pc + WIDTH_VECTOR'(1);
                  cnt_nxt   = CNT_LOAD;
                  state_nxt = S_MEMW;
               end else begin
                  pc_nxt    = pc + WIDTH_VECTOR'(1);
                  state_nxt = S_FETCH;
               end
            end
         end
         S_MEMW: begin
            if (cnt == '0) begin
               state_nxt = S_FETCH;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // PC, stall counter and instruction holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= '0;
         cnt   <= '0;
         instr <= '0;
      end else begin
         pc  <= pc_nxt;
         cnt <= cnt_nxt;
         if (state == S_WAIT) begin
            instr <= imem_rdata;
         end
      end
   end

   assign imem_rd   = (state == S_FETCH);
   assign imem_addr = pc;
   assign valid     = (state == S_ISSUE);
   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_seq
// Purpose  : Directed self-checking bench for instr_fetch_seq (MEM_LAT=2 main
//            instance, MEM_LAT=0 companion instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, next_instr, jump;
   logic [7:0]  start_addr, addr_instr;
   logic        imem_rd, valid, busy, halted;
   logic [7:0]  imem_addr, pc;
   logic [15:0] imem_rdata, instr;

   logic        start0, next0;
   logic [7:0]  start_addr0;
   logic        imem_rd0, valid0, busy0, halted0;
   logic [7:0]  imem_addr0, pc0;
   logic [15:0] imem_rdata0, instr0;

   logic [15:0] mem [0:255];
   int          n_cmp = 0;
   int          n_err = 0;

   // Free-running clock.
   always #5 clk = ~clk;

   // Synchronous instruction memory models, one read port per instance.
   always @(posedge clk) begin
      if (imem_rd)  imem_rdata  <= mem[imem_addr];
      if (imem_rd0) imem_rdata0 <= mem[imem_addr0];
   end

   instr_fetch_seq #(.WIDTH_INSTR(16), .WIDTH_VECTOR(8), .MEM_LAT(2), .HALT_OP(4'b1111)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .valid(valid), .next_instr(next_instr), .jump(jump),
      .addr_instr(addr_instr), .pc(pc), .busy(busy), .halted(halted)
   );

   instr_fetch_seq #(.WIDTH_INSTR(16), .WIDTH_VECTOR(8), .MEM_LAT(0), .HALT_OP(4'b1111)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .start_addr(start_addr0),
      .imem_rd(imem_rd0), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
      .instr(instr0), .valid(valid0), .next_instr(next0), .jump(1'b0),
      .addr_instr(8'h00), .pc(pc0), .busy(busy0), .halted(halted0)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Pulse start; returns at the negedge where the DUT sits in FETCH.
   task automatic start_at(input logic [7:0] a);
      start = 1'b1;
      start_addr = a;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", valid); n_err++; end
      n_cmp++; if (imem_rd !== 1'b0) begin $display("FAIL rst_imem_rd got=%b exp=0", imem_rd); n_err++; end
      n_cmp++; if (pc !== 8'h00) begin $display("FAIL rst_pc got=%h exp=00", pc); n_err++; end
      n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin $display("FAIL rst_busy_halted got=%b%b exp=00", busy, halted); n_err++; end
      n_cmp++; if (instr !== 16'h0000) begin $display("FAIL rst_instr got=%h exp=0000", instr); n_err++; end
      rst_n = 1'b1;
      tick();
      start_at(8'h10);
      tick();
      n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin $display("FAIL rst_prewait busy/valid got=%b%b exp=10", busy, valid); n_err++; end
      // Assert reset in the middle of WAIT and check without any clock edge.
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || valid !== 1'b0 || imem_rd !== 1'b0 || pc !== 8'h00)
         begin $display("FAIL rst_async busy=%b valid=%b rd=%b pc=%h exp 0 0 0 00", busy, valid, imem_rd, pc); n_err++; end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (busy !== 1'b0 || imem_rd !== 1'b0) begin $display("FAIL rst_stays_idle busy=%b rd=%b exp 0 0", busy, imem_rd); n_err++; end
   endtask

   task automatic test_sequential();
      next_instr = 1'b1;
      start_at(8'h10);
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 8'(8'h10 + k) || valid !== 1'b0)
            begin $display("FAIL seq_fetch%0d rd=%b addr=%h valid=%b exp 1 %h 0", k, imem_rd, imem_addr, valid, 8'(8'h10 + k)); n_err++; end
         tick();
         n_cmp++; if (valid !== 1'b0 || imem_rd !== 1'b0)
            begin $display("FAIL seq_wait%0d valid=%b rd=%b exp 0 0", k, valid, imem_rd); n_err++; end
         tick();
         n_cmp++; if (valid !== 1'b1 || pc !== 8'(8'h10 + k) || instr !== 16'(8'h10 + k))
            begin $display("FAIL seq_issue%0d valid=%b pc=%h instr=%h exp 1 %h %h", k, valid, pc, instr, 8'(8'h10 + k), 16'(8'h10 + k)); n_err++; end
         tick();
      end
      next_instr = 1'b0;
      do_reset();
   endtask

   task automatic test_backpressure();
      next_instr = 1'b0;
      start_at(8'h50);
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (valid !== 1'b1 || instr !== 16'h0050 || pc !== 8'h50 || imem_rd !== 1'b0)
            begin $display("FAIL bp_hold%0d valid=%b instr=%h pc=%h rd=%b exp 1 0050 50 0", k, valid, instr, pc, imem_rd); n_err++; end
         tick();
      end
      next_instr = 1'b1;
      tick();
      next_instr = 1'b0;
      n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 8'h51)
         begin $display("FAIL bp_release rd=%b addr=%h exp 1 51", imem_rd, imem_addr); n_err++; end
      do_reset();
   endtask

   task automatic jump_case(input logic [15:0] word, input logic j, input logic [7:0] exp, input string nm);
      mem[8'h05] = word;
      next_instr = 1'b0;
      start_at(8'h05);
      tick();
      tick();
      n_cmp++; if (valid !== 1'b1 || instr !== word)
         begin $display("FAIL %s_issue valid=%b instr=%h exp 1 %h", nm, valid, instr, word); n_err++; end
      jump = j;
      addr_instr = 8'h40;
      next_instr = 1'b1;
      tick();
      next_instr = 1'b0;
      jump = 1'b0;
      n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== exp)
         begin $display("FAIL %s_target rd=%b addr=%h exp 1 %h", nm, imem_rd, imem_addr, exp); n_err++; end
      do_reset();
   endtask

   task automatic test_jump();
      jump_case(16'hC005, 1'b1, 8'h40, "jump_taken");
      jump_case(16'hC005, 1'b0, 8'h06, "jump_not_taken");
      jump_case(16'h0005, 1'b1, 8'h06, "jump_nonjump_op");
      mem[8'h05] = 16'h0005;
   endtask

   task automatic mem_case(input logic [7:0] a, input string nm);
      next_instr = 1'b1;
      start_at(a);
      tick();
      tick();
      n_cmp++; if (valid !== 1'b1 || instr !== mem[a])
         begin $display("FAIL %s_issue valid=%b instr=%h exp 1 %h", nm, valid, instr, mem[a]); n_err++; end
      tick();
      next_instr = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (valid !== 1'b0 || imem_rd !== 1'b0 || busy !== 1'b1)
            begin $display("FAIL %s_stall%0d valid=%b rd=%b busy=%b exp 0 0 1", nm, k, valid, imem_rd, busy); n_err++; end
         tick();
      end
      n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 8'(a + 8'h01))
         begin $display("FAIL %s_refetch rd=%b addr=%h exp 1 %h", nm, imem_rd, imem_addr, 8'(a + 8'h01)); n_err++; end
      do_reset();
   endtask

   task automatic test_mem_stall();
      mem_case(8'h30, "stall_1001");
      mem_case(8'h34, "stall_1010");
      // Zero-latency build goes straight back to FETCH.
      next0 = 1'b1;
      start0 = 1'b1;
      start_addr0 = 8'h30;
      tick();
      start0 = 1'b0;
      tick();
      tick();
      n_cmp++; if (valid0 !== 1'b1 || instr0 !== 16'h9030)
         begin $display("FAIL lat0_issue valid=%b instr=%h exp 1 9030", valid0, instr0); n_err++; end
      tick();
      n_cmp++; if (imem_rd0 !== 1'b1 || imem_addr0 !== 8'h31)
         begin $display("FAIL lat0_refetch rd=%b addr=%h exp 1 31", imem_rd0, imem_addr0); n_err++; end
      next0 = 1'b0;
      do_reset();
   endtask

   task automatic test_wrap_halt();
      int guard;
      int rd_seen;
      next_instr = 1'b1;
      start_at(8'hFF);
      n_cmp++; if (imem_addr !== 8'hFF) begin $display("FAIL wrap_first addr=%h exp ff", imem_addr); n_err++; end
      tick();
      tick();
      tick();
      n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00)
         begin $display("FAIL wrap_addr rd=%b addr=%h exp 1 00", imem_rd, imem_addr); n_err++; end
      // mem[0x00] holds HALT_OP; wait (bounded) for the halt state.
      guard = 0;
      while (halted !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h00)
         begin $display("FAIL halt_state halted=%b busy=%b pc=%h exp 1 0 00", halted, busy, pc); n_err++; end
      rd_seen = 0;
      for (int k = 0; k < 5; k++) begin
         if (imem_rd === 1'b1) rd_seen++;
         tick();
      end
      n_cmp++; if (rd_seen != 0 || halted !== 1'b1)
         begin $display("FAIL halt_no_fetch reads=%0d halted=%b exp 0 1", rd_seen, halted); n_err++; end
      next_instr = 1'b0;
      start_at(8'h20);
      n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 8'h20 || halted !== 1'b0 || busy !== 1'b1)
         begin $display("FAIL halt_restart rd=%b addr=%h halted=%b busy=%b exp 1 20 0 1", imem_rd, imem_addr, halted, busy); n_err++; end
      // start is ignored while busy.
      start_at(8'h77);
      tick();
      n_cmp++; if (valid !== 1'b1 || pc !== 8'h20)
         begin $display("FAIL start_ignored valid=%b pc=%h exp 1 20", valid, pc); n_err++; end
      do_reset();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      mem[8'h00] = 16'hF000;
      mem[8'h30] = 16'h9030;
      mem[8'h34] = 16'hA034;
      rst_n = 1'b0;
      start = 1'b0;
      start_addr = 8'h00;
      next_instr = 1'b0;
      jump = 1'b0;
      addr_instr = 8'h00;
      start0 = 1'b0;
      start_addr0 = 8'h00;
      next0 = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_jump();
      test_mem_stall();
      test_wrap_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
